// File: rtl/rom_burst.sv
// Read-only word store streamed out in bursts: start address plus length, with a stall input.
// Define ROM_BURST_OUTREG_EN for a second output register stage, which gives a read latency of 2.
module rom_burst #(
    parameter int                DATA_W = 8,
    parameter int                ADDR_W = 9,
    parameter logic [DATA_W-1:0] FILL   = {DATA_W{1'b1}}
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Inicio,
    input  logic [ADDR_W-1:0] Endereco,
    input  logic [ADDR_W:0]   Tamanho,
    input  logic              Pausa,
    output logic [DATA_W-1:0] Dados,
    output logic              Valido,
    output logic              Fim,
    output logic              Ocupado
);

    typedef enum logic [1:0] {IDLE, LER, FIM} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_count;
    logic [DATA_W-1:0]   r_dados;
    logic                r_valido;
    logic                w_read;
    logic                w_accept;
    logic                w_drain;
    logic                w_fim;
    logic                w_ocupado;

    function automatic logic [DATA_W-1:0] romWord(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] w_word;
        case (a)
            ADDR_W'(0): w_word = DATA_W'(8'd2);
            ADDR_W'(1): w_word = DATA_W'(8'd6);
            ADDR_W'(2): w_word = DATA_W'(8'd7);
            ADDR_W'(3): w_word = DATA_W'(8'd2);
            ADDR_W'(4): w_word = DATA_W'(8'd2);
            ADDR_W'(5): w_word = DATA_W'(8'd0);
            ADDR_W'(6): w_word = DATA_W'(8'd255);
            ADDR_W'(7): w_word = DATA_W'(8'd3);
            ADDR_W'(8): w_word = DATA_W'(8'd255);
            ADDR_W'(9): w_word = DATA_W'(8'd1);
            default:    w_word = FILL;
        endcase
        return w_word;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = (Tamanho == '0) ? FIM : LER;
                end
            end
            LER: begin
                if (!Pausa && r_count == (ADDR_W+1)'(1)) begin
                    w_next = FIM;
                end
            end
            FIM:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // w_drain keeps a new request out while the delayed Fim is still draining.
    always_comb begin
        w_read    = (r_state == LER) && !Pausa;
        w_fim     = (r_state == FIM);
        w_ocupado = (r_state != IDLE);
        w_accept  = (r_state == IDLE) && Inicio && !w_drain;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_addr   <= '0;
            r_count  <= '0;
            r_dados  <= '0;
            r_valido <= 1'b0;
        end else begin
            r_valido <= w_read;
            if (w_read) begin
                r_dados <= romWord(r_addr);
                r_addr  <= r_addr + ADDR_W'(1);
                r_count <= r_count - (ADDR_W+1)'(1);
            end
            if (w_accept && Tamanho != '0) begin
                r_addr  <= Endereco;
                r_count <= Tamanho;
            end
        end
    end

`ifdef ROM_BURST_OUTREG_EN
    logic [DATA_W-1:0] r_dados2;
    logic              r_valido2;
    logic              r_fimD;

    // The second stage always advances, so a stall never holds back words already read.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_dados2  <= '0;
            r_valido2 <= 1'b0;
            r_fimD    <= 1'b0;
        end else begin
            if (r_valido) begin
                r_dados2 <= r_dados;
            end
            r_valido2 <= r_valido;
            r_fimD    <= w_fim;
        end
    end

    assign w_drain = r_fimD;
    assign Dados   = r_dados2;
    assign Valido  = r_valido2;
    assign Fim     = r_fimD;
    assign Ocupado = w_ocupado | r_fimD;
`else
    assign w_drain = 1'b0;
    assign Dados   = r_dados;
    assign Valido  = r_valido;
    assign Fim     = w_fim;
    assign Ocupado = w_ocupado;
`endif

endmodule
